// File: rtl/hdlc_rx_deframer_if.sv
// Line-side bit input and the received-octet/status strobes of the HDLC deframer.
// Latency: none, signal bundle only.
// Backpressure: none; the consumer must take every data_valid strobe.
interface hdlc_rx_deframer_if;
  logic       rxdata;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sof;
  logic       eop;
  logic       fcs_ok;
  logic       align_err;
  logic       abort;
  logic       runt;
  logic       active;

  // Line driver and receive-buffer side
  modport master (
    output rxdata,
    input  data_out, data_valid, sof, eop, fcs_ok, align_err, abort, runt, active
  );

  // Deframer side
  modport slave (
    input  rxdata,
    output data_out, data_valid, sof, eop, fcs_ok, align_err, abort, runt, active
  );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// Bit-serial HDLC receive deframer: flag hunt, zero destuffing, LSB-first octet assembly, CRC-16 FCS check.
// Latency: octet k out 1 cycle after the last data bit of octet k+2; eop 1 cycle after the flag's closing 0.
// Backpressure: none; every data_valid strobe must be accepted by the consumer.
module hdlc_rx_deframer (
  input  logic               netclk,
  input  logic               reset_n,
  hdlc_rx_deframer_if.slave  bus
);

  typedef enum logic {
    ST_HUNT     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_GOOD = 16'h1D0F;

  // Framing state
  state_t      r_state;
  logic [2:0]  r_ones;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shreg;
  logic [15:0] r_crc;
  logic [15:0] r_crc_chk;
  logic [7:0]  r_hb0;
  logic [7:0]  r_hb1;
  logic [1:0]  r_octcnt;

  // Registered outputs
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_sof;
  logic        r_eop;
  logic        r_fcs_ok;
  logic        r_align_err;
  logic        r_abort;
  logic        r_runt;
  logic        r_active;

  // Per-bit classification and next-value terms
  logic        w_bit;
  logic        w_is_flag;
  logic        w_is_abort;
  logic        w_is_data;
  logic        w_oct_done;
  logic [2:0]  w_ones_nxt;
  logic [7:0]  w_shreg_nxt;
  logic [15:0] w_crc_nxt;
  logic [1:0]  w_octcnt_inc;

  // Classify the incoming bit against the run of ones seen before it
  always_comb begin
    w_bit        = bus.rxdata;
    w_is_flag    = !w_bit && (r_ones == 3'd6);
    w_is_abort   = w_bit && (r_ones >= 3'd6);
    // A 1 after five ones is held back (could be a flag); a 0 after five ones is a stuffed zero
    w_is_data    = w_bit ? (r_ones < 3'd5) : ((r_ones != 3'd5) && (r_ones != 3'd6));
    w_ones_nxt   = !w_bit ? 3'd0 : ((r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1);
    w_shreg_nxt  = {w_bit, r_shreg[7:1]};
    w_crc_nxt    = {r_crc[14:0], 1'b0} ^ ((w_bit ^ r_crc[15]) ? CRC_POLY : 16'h0000);
    w_oct_done   = w_is_data && (r_bitcnt == 3'd7);
    w_octcnt_inc = (r_octcnt == 2'd3) ? 2'd3 : r_octcnt + 2'd1;
  end

  // Hunt/in-frame FSM with octet assembly, CRC, two-octet FCS holdback and output strobes
  always_ff @(posedge netclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_HUNT;
      r_ones       <= 3'd0;
      r_bitcnt     <= 3'd0;
      r_shreg      <= 8'h00;
      r_crc        <= CRC_INIT;
      r_crc_chk    <= CRC_INIT;
      r_hb0        <= 8'h00;
      r_hb1        <= 8'h00;
      r_octcnt     <= 2'd0;
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_eop        <= 1'b0;
      r_fcs_ok     <= 1'b0;
      r_align_err  <= 1'b0;
      r_abort      <= 1'b0;
      r_runt       <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_eop        <= 1'b0;
      r_fcs_ok     <= 1'b0;
      r_align_err  <= 1'b0;
      r_abort      <= 1'b0;
      r_runt       <= 1'b0;
      r_ones       <= w_ones_nxt;

      if (w_is_flag) begin
        // A flag closes whatever was in progress and always opens a new frame
        if (r_state == ST_IN_FRAME) begin
          if (r_octcnt == 2'd3) begin
            r_eop       <= 1'b1;
            // The flag's leading 0 and five 1s were shifted in as data; the last octet snapshot excludes them
            r_fcs_ok    <= (r_crc_chk == CRC_GOOD);
            r_align_err <= (r_bitcnt != 3'd6);
          end else if (r_octcnt != 2'd0) begin
            r_runt      <= 1'b1;
          end
        end
        r_state   <= ST_IN_FRAME;
        r_active  <= 1'b1;
        r_bitcnt  <= 3'd0;
        r_shreg   <= 8'h00;
        r_crc     <= CRC_INIT;
        r_crc_chk <= CRC_INIT;
        r_hb0     <= 8'h00;
        r_hb1     <= 8'h00;
        r_octcnt  <= 2'd0;
      end else begin
        case (r_state)
          ST_HUNT: begin
            // Everything other than a flag is ignored while hunting
          end
          ST_IN_FRAME: begin
            if (w_is_abort) begin
              // Seventh consecutive 1: abort if octets were collected, otherwise plain idle mark
              r_state  <= ST_HUNT;
              r_active <= 1'b0;
              r_abort  <= (r_octcnt != 2'd0);
            end else if (w_is_data) begin
              r_shreg  <= w_shreg_nxt;
              r_bitcnt <= r_bitcnt + 3'd1;
              r_crc    <= w_crc_nxt;
              if (w_oct_done) begin
                r_crc_chk <= w_crc_nxt;
                // Two newest octets stay held back: at the closing flag they are the FCS
                if (r_octcnt >= 2'd2) begin
                  r_data_out   <= r_hb1;
                  r_data_valid <= 1'b1;
                  r_sof        <= (r_octcnt == 2'd2);
                end
                r_hb1    <= r_hb0;
                r_hb0    <= w_shreg_nxt;
                r_octcnt <= w_octcnt_inc;
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.sof        = r_sof;
  assign bus.eop        = r_eop;
  assign bus.fcs_ok     = r_fcs_ok;
  assign bus.align_err  = r_align_err;
  assign bus.abort      = r_abort;
  assign bus.runt       = r_runt;
  assign bus.active     = r_active;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: a small HDLC transmit model builds line bit streams,
// a negedge monitor collects output strobes, and each scenario task checks its own results.
module tb_hdlc_rx_deframer;

  logic netclk;
  logic reset_n;

  hdlc_rx_deframer_if bus ();

  hdlc_rx_deframer dut (
    .netclk  (netclk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial netclk = 1'b0;
  always #5 netclk = ~netclk;

  int errors = 0;
  int checks = 0;

  // Transmit-side model state
  bit          txq[$];
  int          tx_ones;
  logic [15:0] tx_crc;

  // Monitor records
  logic [7:0] q_dat[$];
  bit         q_sof[$];
  bit         q_fcs[$];
  bit         q_aln[$];
  int         n_abort = 0;
  int         n_runt  = 0;
  int         n_coinc = 0;

  // Collect output strobes away from the active edge
  always @(negedge netclk) begin
    if (bus.data_valid) begin
      q_dat.push_back(bus.data_out);
      q_sof.push_back(bus.sof);
    end
    if (bus.eop) begin
      q_fcs.push_back(bus.fcs_ok);
      q_aln.push_back(bus.align_err);
    end
    if (bus.abort) n_abort++;
    if (bus.runt) n_runt++;
    if (bus.data_valid && bus.eop) n_coinc++;
  end

  // ---------------- transmit model ----------------
  task automatic tx_flag();
    txq.push_back(1'b0);
    for (int i = 0; i < 6; i++) txq.push_back(1'b1);
    txq.push_back(1'b0);
    tx_ones = 0;
    tx_crc  = 16'hFFFF;
  endtask

  // One data bit: CRC over the true bit, line carries b^flip, zero inserted after five line ones
  task automatic tx_dbit(input bit b, input bit flip);
    bit lb;
    tx_crc = {tx_crc[14:0], 1'b0} ^ ((b ^ tx_crc[15]) ? 16'h1021 : 16'h0000);
    lb = b ^ flip;
    txq.push_back(lb);
    if (lb) begin
      tx_ones++;
      if (tx_ones == 5) begin
        txq.push_back(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic tx_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_dbit(v[i], 1'b0);
  endtask

  task automatic tx_byte_flip(input logic [7:0] v, input int fbit);
    for (int i = 0; i < 8; i++) tx_dbit(v[i], (i == fbit));
  endtask

  // Complemented CRC, register MSB first on the line
  task automatic tx_fcs();
    logic [15:0] f;
    f = ~tx_crc;
    for (int i = 15; i >= 0; i--) tx_dbit(f[i], 1'b0);
  endtask

  task automatic tx_raw_ones(input int n);
    for (int i = 0; i < n; i++) txq.push_back(1'b1);
  endtask

  task automatic play_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge netclk);
      bus.rxdata = txq.pop_front();
    end
  endtask

  task automatic play();
    play_n(txq.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge netclk);
      bus.rxdata = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bd;
    int ba;
    int br;
    int be;
    bus.rxdata = 1'b1;
    reset_n    = 1'b0;
    repeat (3) @(negedge netclk);
    checks++;
    if ({bus.data_out, bus.data_valid, bus.sof, bus.eop, bus.fcs_ok, bus.align_err,
         bus.abort, bus.runt, bus.active} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%0h dv=%0b active=%0b, want all zero",
               bus.data_out, bus.data_valid, bus.active);
    end
    checks++;
    if (dut.r_crc !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_crc: got %0h want ffff", dut.r_crc);
    end
    bd = q_dat.size(); ba = n_abort; br = n_runt; be = q_fcs.size();
    reset_n = 1'b1;
    idle(20);
    checks++;
    if ((q_dat.size() - bd) + (n_abort - ba) + (n_runt - br) + (q_fcs.size() - be) !== 0) begin
      errors++;
      $display("FAIL reset_idle_strobes: got %0d strobes want 0",
               (q_dat.size() - bd) + (n_abort - ba) + (n_runt - br) + (q_fcs.size() - be));
    end
    checks++;
    if (bus.active !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_active: got %0b want 0", bus.active);
    end
  endtask

  task automatic test_loopback();
    int bd = q_dat.size();
    int be = q_fcs.size();
    int ba = n_abort;
    logic [23:0] got;
    logic [2:0]  gsof;
    tx_raw_ones(10);
    tx_flag(); tx_byte(8'h01); tx_byte(8'h7E); tx_byte(8'hFF); tx_fcs(); tx_flag();
    play();
    @(negedge netclk);
    checks++;
    if (bus.eop !== 1'b1) begin
      errors++;
      $display("FAIL loopback_eop_latency: got eop=%0b want 1", bus.eop);
    end
    bus.rxdata = 1'b1;
    idle(12);
    checks++;
    if (q_dat.size() - bd !== 3) begin
      errors++;
      $display("FAIL loopback_count: got %0d want 3", q_dat.size() - bd);
    end
    got = '0; gsof = '0;
    for (int i = 0; i < 3; i++) begin
      if (bd + i < q_dat.size()) begin
        got[23 - 8*i -: 8] = q_dat[bd + i];
        gsof[2 - i]        = q_sof[bd + i];
      end
    end
    checks++;
    if (got !== 24'h017EFF) begin
      errors++;
      $display("FAIL loopback_data: got %06h want 017eff", got);
    end
    checks++;
    if (gsof !== 3'b100) begin
      errors++;
      $display("FAIL loopback_sof: got %03b want 100", gsof);
    end
    checks++;
    if (q_fcs.size() - be !== 1) begin
      errors++;
      $display("FAIL loopback_eop_count: got %0d want 1", q_fcs.size() - be);
    end
    checks++;
    if (q_fcs.size() <= be || q_fcs[be] !== 1'b1 || q_aln[be] !== 1'b0) begin
      errors++;
      $display("FAIL loopback_status: got fcs_ok/align_err %0b/%0b want 1/0",
               (q_fcs.size() > be) ? q_fcs[be] : 1'b0, (q_aln.size() > be) ? q_aln[be] : 1'b1);
    end
    checks++;
    if (n_abort - ba !== 0) begin
      errors++;
      $display("FAIL loopback_abort: got %0d want 0", n_abort - ba);
    end
  endtask

  task automatic test_back_to_back();
    int bd = q_dat.size();
    int be = q_fcs.size();
    logic [39:0] got;
    logic [4:0]  gsof;
    int          nstuff;
    tx_flag(); tx_byte(8'hFF); tx_byte(8'hFF); tx_fcs();
    tx_flag(); tx_byte(8'h55); tx_byte(8'h81); tx_byte(8'h3C); tx_fcs(); tx_flag();
    nstuff = txq.size();
    play();
    idle(12);
    checks++;
    if (nstuff <= 8 + 16 + 16 + 8 + 24 + 16 + 8) begin
      errors++;
      $display("FAIL b2b_line_len: got %0d line bits want stuffed length above 96", nstuff);
    end
    checks++;
    if (q_dat.size() - bd !== 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 5", q_dat.size() - bd);
    end
    got = '0; gsof = '0;
    for (int i = 0; i < 5; i++) begin
      if (bd + i < q_dat.size()) begin
        got[39 - 8*i -: 8] = q_dat[bd + i];
        gsof[4 - i]        = q_sof[bd + i];
      end
    end
    checks++;
    if (got !== 40'hFFFF55813C) begin
      errors++;
      $display("FAIL b2b_data: got %010h want ffff55813c", got);
    end
    checks++;
    if (gsof !== 5'b10100) begin
      errors++;
      $display("FAIL b2b_sof: got %05b want 10100", gsof);
    end
    checks++;
    if (q_fcs.size() - be !== 2) begin
      errors++;
      $display("FAIL b2b_eop_count: got %0d want 2", q_fcs.size() - be);
    end
    checks++;
    if (q_fcs.size() < be + 2 || q_fcs[be] !== 1'b1 || q_fcs[be + 1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_fcs_ok: got eops=%0d not both fcs_ok want 2 good", q_fcs.size() - be);
    end
    checks++;
    if (n_coinc !== 0) begin
      errors++;
      $display("FAIL dv_eop_overlap: got %0d want 0", n_coinc);
    end
  endtask

  task automatic test_fcs_error();
    int bd = q_dat.size();
    int be = q_fcs.size();
    logic [23:0] got;
    tx_flag(); tx_byte_flip(8'h01, 0); tx_byte(8'h7E); tx_byte(8'hFF); tx_fcs(); tx_flag();
    play();
    idle(12);
    got = '0;
    for (int i = 0; i < 3; i++)
      if (bd + i < q_dat.size()) got[23 - 8*i -: 8] = q_dat[bd + i];
    checks++;
    if (q_dat.size() - bd !== 3 || got !== 24'h007EFF) begin
      errors++;
      $display("FAIL fcs_err_data: got %0d octets %06h want 3 octets 007eff", q_dat.size() - bd, got);
    end
    checks++;
    if (q_fcs.size() - be !== 1) begin
      errors++;
      $display("FAIL fcs_err_eop_count: got %0d want 1", q_fcs.size() - be);
    end
    checks++;
    if (q_fcs.size() <= be || q_fcs[be] !== 1'b0) begin
      errors++;
      $display("FAIL fcs_err_flag: got fcs_ok=1 or no eop want 0");
    end
  endtask

  task automatic test_abort();
    int bd = q_dat.size();
    int be = q_fcs.size();
    int ba = n_abort;
    tx_flag(); tx_byte(8'h12); tx_byte(8'h34); tx_raw_ones(8);
    play();
    idle(30);
    checks++;
    if (n_abort - ba !== 1) begin
      errors++;
      $display("FAIL abort_count: got %0d want 1", n_abort - ba);
    end
    checks++;
    if (q_fcs.size() - be !== 0) begin
      errors++;
      $display("FAIL abort_eop: got %0d want 0", q_fcs.size() - be);
    end
    checks++;
    if (q_dat.size() - bd !== 0) begin
      errors++;
      $display("FAIL abort_data: got %0d want 0", q_dat.size() - bd);
    end
    checks++;
    if (bus.active !== 1'b0) begin
      errors++;
      $display("FAIL abort_hunt: got active=%0b want 0", bus.active);
    end
  endtask

  task automatic test_fill_runt_align();
    int bd = q_dat.size();
    int be = q_fcs.size();
    int ba = n_abort;
    int br = n_runt;
    for (int i = 0; i < 10; i++) tx_flag();
    play();
    idle(12);
    checks++;
    if ((q_dat.size() - bd) + (q_fcs.size() - be) + (n_abort - ba) + (n_runt - br) !== 0) begin
      errors++;
      $display("FAIL flag_fill: got %0d strobes want 0",
               (q_dat.size() - bd) + (q_fcs.size() - be) + (n_abort - ba) + (n_runt - br));
    end
    tx_flag(); tx_byte(8'hAA); tx_flag();
    play();
    idle(12);
    checks++;
    if (n_runt - br !== 1) begin
      errors++;
      $display("FAIL runt_count: got %0d want 1", n_runt - br);
    end
    checks++;
    if ((q_dat.size() - bd) + (q_fcs.size() - be) !== 0) begin
      errors++;
      $display("FAIL runt_no_data: got %0d strobes want 0", (q_dat.size() - bd) + (q_fcs.size() - be));
    end
    tx_flag(); tx_byte(8'h01); tx_byte(8'h7E); tx_byte(8'hFF); tx_fcs(); tx_flag();
    txq.delete(8);
    play();
    idle(12);
    checks++;
    if (q_fcs.size() - be !== 1) begin
      errors++;
      $display("FAIL align_eop_count: got %0d want 1", q_fcs.size() - be);
    end
    checks++;
    if (q_aln.size() <= be || q_aln[be] !== 1'b1) begin
      errors++;
      $display("FAIL align_err_flag: got 0 or no eop want 1");
    end
  endtask

  task automatic test_reset_mid_frame();
    int bd = q_dat.size();
    int be = q_fcs.size();
    int ba = n_abort;
    int br = n_runt;
    logic [15:0] got;
    tx_flag(); tx_byte(8'h11); tx_byte(8'h22); tx_byte(8'h33); tx_fcs(); tx_flag();
    play_n(20);
    checks++;
    if (bus.active !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre_active: got %0b want 1", bus.active);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.data_out, bus.data_valid, bus.sof, bus.eop, bus.fcs_ok, bus.align_err,
         bus.abort, bus.runt, bus.active} !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_async: got active=%0b dout=%0h want all zero", bus.active, bus.data_out);
    end
    @(negedge netclk);
    @(negedge netclk);
    reset_n = 1'b1;
    play();
    idle(12);
    checks++;
    if ((q_dat.size() - bd) + (q_fcs.size() - be) + (n_abort - ba) + (n_runt - br) !== 0) begin
      errors++;
      $display("FAIL midreset_partial: got %0d strobes want 0",
               (q_dat.size() - bd) + (q_fcs.size() - be) + (n_abort - ba) + (n_runt - br));
    end
    tx_flag(); tx_byte(8'h5A); tx_byte(8'hC3); tx_fcs(); tx_flag();
    play();
    idle(12);
    got = '0;
    for (int i = 0; i < 2; i++)
      if (bd + i < q_dat.size()) got[15 - 8*i -: 8] = q_dat[bd + i];
    checks++;
    if (q_dat.size() - bd !== 2 || got !== 16'h5AC3) begin
      errors++;
      $display("FAIL midreset_next_data: got %0d octets %04h want 2 octets 5ac3", q_dat.size() - bd, got);
    end
    checks++;
    if (q_fcs.size() - be !== 1 || q_fcs[be] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_next_eop: got %0d eops or bad fcs want 1 good", q_fcs.size() - be);
    end
  endtask

  initial begin
    bus.rxdata = 1'b1;
    reset_n    = 1'b0;
    tx_ones    = 0;
    tx_crc     = 16'hFFFF;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_fcs_error();
    test_abort();
    test_fill_runt_align();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
